// File: rtl/apb_pkg.sv
// Shared types and helpers for the task_3_abp APB slaves.
package apb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CLS_RW  = 2'd0,
    CLS_RO  = 2'd1,
    CLS_ERR = 2'd2
  } addr_cls_t;

  // Ceiling log2, never below 1 so a counter/index always has at least one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Classifies a word address into RW bank, RO status window or unmapped.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int AWIDTH           = 4,
  parameter int REGWN            = 5,
  parameter int REGRN            = 3,
  parameter int REGR_ADDR_OFFSET = 5,
  parameter int RW_IW            = clog2(REGWN)
) (
  input  logic [AWIDTH-1:0] addr,
  output addr_cls_t         cls,
  output logic [RW_IW-1:0]  rw_idx,
  output logic [REGRN-1:0]  ro_idx
);

  int a;

  // NOTE: every output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    a      = int'(addr);
    cls    = CLS_ERR;
    rw_idx = RW_IW'(a);
    ro_idx = REGRN'(a - REGR_ADDR_OFFSET);
    // RW is tested first so it wins when the two windows overlap.
    if (a < REGWN) begin
      cls = CLS_RW;
    end else if (a >= REGR_ADDR_OFFSET && a < REGR_ADDR_OFFSET + REGRN) begin
      cls = CLS_RO;
    end
  end

endmodule

// File: rtl/apb_reg_ctrl.sv
// APB3 slave front-end: owns the RW config bank and forwards RO reads to the status block.
module apb_reg_ctrl
  import apb_pkg::*;
#(
  parameter int AWIDTH           = 4,
  parameter int DWIDTH           = 8,
  parameter int REGWN            = 5,
  parameter int REGRN            = 3,
  parameter int REGR_ADDR_OFFSET = 5,
  parameter int WAIT_STATES      = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [AWIDTH-1:0]       PADDR,
  input  logic [DWIDTH-1:0]       PWDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [DWIDTH-1:0]       PRDATA,
  output logic [REGRN-1:0]        pselr,
  input  logic [DWIDTH-1:0]       regr_prdata,
  output logic [REGWN*DWIDTH-1:0] regw_q,
  output logic [REGWN-1:0]        regw_wr_stb
);

  localparam int CNT_W = clog2(WAIT_STATES + 1);
  localparam int RW_IW = clog2(REGWN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);

  state_t             state;
  addr_cls_t          dec_cls;
  addr_cls_t          cls_q;
  logic [RW_IW-1:0]   dec_rw_idx;
  logic [RW_IW-1:0]   rw_idx_q;
  logic [REGRN-1:0]   dec_ro_idx;
  logic               wr_q;
  logic [CNT_W-1:0]   cnt;
  logic [DWIDTH-1:0]  regw [REGWN];
  logic               access_done;
  logic               commit;

  apb_addr_decode #(
    .AWIDTH          (AWIDTH),
    .REGWN           (REGWN),
    .REGRN           (REGRN),
    .REGR_ADDR_OFFSET(REGR_ADDR_OFFSET),
    .RW_IW           (RW_IW)
  ) u_decode (
    .addr  (PADDR),
    .cls   (dec_cls),
    .rw_idx(dec_rw_idx),
    .ro_idx(dec_ro_idx)
  );

  assign access_done = (state == ST_ACCESS) && (cnt == CNT_LAST) && PSEL && PENABLE;
  assign commit      = access_done && wr_q && (cls_q == CLS_RW);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cls_q       <= CLS_ERR;
      rw_idx_q    <= '0;
      wr_q        <= 1'b0;
      pselr       <= '0;
      regw_wr_stb <= '0;
      // NOTE: the config bank is software-visible, so it is reset like any other register.
      for (int i = 0; i < REGWN; i++) regw[i] <= '0;
    end else begin
      regw_wr_stb <= '0;
      case (state)
        ST_IDLE: begin
          // PENABLE high without a preceding SETUP is a protocol error and is ignored.
          if (PSEL && !PENABLE) begin
            state    <= ST_ACCESS;
            cnt      <= '0;
            wr_q     <= PWRITE;
            cls_q    <= dec_cls;
            rw_idx_q <= dec_rw_idx;
            if (dec_cls == CLS_RO) pselr <= dec_ro_idx;
          end
        end
        ST_ACCESS: begin
          if (!PSEL) begin
            state <= ST_IDLE;
          end else if (access_done) begin
            state <= ST_IDLE;
            if (commit) begin
              regw[rw_idx_q]        <= PWDATA;
              regw_wr_stb[rw_idx_q] <= 1'b1;
            end
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    regw_q = '0;
    for (int i = 0; i < REGWN; i++) regw_q[i*DWIDTH +: DWIDTH] = regw[i];
  end

  assign PREADY  = access_done;
  assign PSLVERR = access_done && ((cls_q == CLS_ERR) || (wr_q && cls_q == CLS_RO));

  always_comb begin
    PRDATA = '0;
    if (access_done && !wr_q) begin
      case (cls_q)
        CLS_RW:  PRDATA = regw[rw_idx_q];
        CLS_RO:  PRDATA = regr_prdata;
        default: PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_ctrl.sv
// Bench for apb_reg_ctrl: three instances (WAIT_STATES 0, 2, 3) checked against a register-map model.
module tb_apb_reg_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        psel [3];
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [7:0]  pwdata;
  logic        pready [3];
  logic        pslverr [3];
  logic [7:0]  prdata [3];
  logic [2:0]  pselr [3];
  logic [7:0]  regr_prdata [3];
  logic [39:0] regw_q [3];
  logic [4:0]  stb_o [3];

  logic [7:0]  status_val [8];
  logic [7:0]  m_regw [3][5];
  logic [2:0]  m_pselr [3];

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign regr_prdata[g] = status_val[pselr[g]];
    apb_reg_ctrl #(
      .AWIDTH(4), .DWIDTH(8), .REGWN(5), .REGRN(3), .REGR_ADDR_OFFSET(5),
      .WAIT_STATES(g == 0 ? 0 : g + 1)
    ) u_dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .PSEL       (psel[g]),
      .PENABLE    (penable),
      .PWRITE     (pwrite),
      .PADDR      (paddr),
      .PWDATA     (pwdata),
      .PREADY     (pready[g]),
      .PSLVERR    (pslverr[g]),
      .PRDATA     (prdata[g]),
      .pselr      (pselr[g]),
      .regr_prdata(regr_prdata[g]),
      .regw_q     (regw_q[g]),
      .regw_wr_stb(stb_o[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : k + 1;
  endfunction

  // 0 = RW bank, 1 = RO status window, 2 = unmapped
  function automatic int region(input logic [3:0] addr);
    if (addr < 5) return 0;
    if (addr >= 5 && addr < 8) return 1;
    return 2;
  endfunction

  function automatic logic [39:0] packed_bank(input int k);
    logic [39:0] q;
    for (int i = 0; i < 5; i++) q[i*8 +: 8] = m_regw[k][i];
    return q;
  endfunction

  function automatic logic exp_err(input bit wr, input logic [3:0] addr);
    return (region(addr) == 2) || (wr && region(addr) == 1);
  endfunction

  function automatic logic [7:0] exp_rdata(input int k, input bit wr, input logic [3:0] addr);
    if (wr) return 8'h00;
    if (region(addr) == 0) return m_regw[k][addr];
    if (region(addr) == 1) return status_val[addr - 4'd5];
    return 8'h00;
  endfunction

  function automatic logic [4:0] exp_stb(input bit wr, input logic [3:0] addr);
    if (wr && region(addr) == 0) return 5'(1 << addr);
    return 5'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pselr[k] = 3'd0;
      for (int i = 0; i < 5; i++) m_regw[k][i] = 8'h00;
    end
  endtask

  task automatic model_xfer(input int k, input bit wr, input logic [3:0] addr, input logic [7:0] wd,
                            input bit completes);
    if (region(addr) == 1) m_pselr[k] = 3'(addr - 4'd5);
    if (completes && wr && region(addr) == 0) m_regw[k][addr] = wd;
  endtask

  // ---------------- bus driver (observation only) ----------------
  // Entered and left between a negedge and the following posedge.
  task automatic do_xfer(input int k, input bit wr, input logic [3:0] addr, input logic [7:0] wd,
                         input int abort_at,
                         output int nwait, output logic [7:0] rd, output logic err,
                         output logic [2:0] psel_seen, output logic [4:0] stb_after,
                         output logic [39:0] q_after, output bit early);
    bit finished;
    nwait = 0; rd = 8'h00; err = 1'b0; early = 1'b0; finished = 1'b0;
    psel[k] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge PCLK); #1 penable = 1'b1;
    @(negedge PCLK); psel_seen = pselr[k];
    for (int c = 0; c < 20 && !finished; c++) begin
      if (abort_at >= 0 && c == abort_at) begin
        psel[k] = 1'b0; penable = 1'b0;
        @(posedge PCLK);
        finished = 1'b1;
      end else if (pready[k]) begin
        rd = prdata[k]; err = pslverr[k];
        @(posedge PCLK); #1 psel[k] = 1'b0; penable = 1'b0;
        finished = 1'b1;
      end else begin
        if (prdata[k] !== 8'h00 || pslverr[k] !== 1'b0) early = 1'b1;
        nwait++;
        @(negedge PCLK);
      end
    end
    if (!finished) begin
      nwait = -1; psel[k] = 1'b0; penable = 1'b0;
    end
    @(negedge PCLK); stb_after = stb_o[k]; q_after = regw_q[k];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({pready[k], pslverr[k], prdata[k], pselr[k], regw_q[k], stb_o[k]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got rdy=%b err=%b rd=%h sel=%h q=%h stb=%b required all 0",
                 k, pready[k], pslverr[k], prdata[k], pselr[k], regw_q[k], stb_o[k]);
      end
    end
  endtask

  task automatic test_write_ws0();
    int n; logic [7:0] rd; logic e; logic [2:0] ps; logic [4:0] sb; logic [39:0] q; bit early;
    do_xfer(0, 1'b1, 4'd2, 8'h5A, -1, n, rd, e, ps, sb, q, early);
    model_xfer(0, 1'b1, 4'd2, 8'h5A, 1'b1);
    checks++; if (n !== 0) begin errors++; $display("FAIL wr_ws0_latency: got %0d required 0", n); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_ws0_slverr: got %b required 0", e); end
    checks++; if (sb !== 5'b00100) begin errors++; $display("FAIL wr_ws0_stb: got %b required 00100", sb); end
    checks++; if (q[23:16] !== 8'h5A) begin errors++; $display("FAIL wr_ws0_data: got %h required 5a", q[23:16]); end
    @(negedge PCLK);
    checks++; if (stb_o[0] !== 5'b0) begin errors++; $display("FAIL wr_ws0_stb_width: got %b required 00000", stb_o[0]); end
  endtask

  task automatic test_read_ro();
    int n; logic [7:0] rd; logic e; logic [2:0] ps; logic [4:0] sb; logic [39:0] q; bit early;
    status_val[1] = 8'hC3;
    do_xfer(0, 1'b0, 4'd6, 8'h00, -1, n, rd, e, ps, sb, q, early);
    model_xfer(0, 1'b0, 4'd6, 8'h00, 1'b1);
    checks++; if (ps !== 3'd1) begin errors++; $display("FAIL ro_pselr: got %0d required 1", ps); end
    checks++; if (rd !== 8'hC3) begin errors++; $display("FAIL ro_rdata: got %h required c3", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL ro_slverr: got %b required 0", e); end
  endtask

  task automatic test_errors();
    int n; logic [7:0] rd; logic e; logic [2:0] ps; logic [4:0] sb; logic [39:0] q; bit early;
    do_xfer(0, 1'b1, 4'd6, 8'hFF, -1, n, rd, e, ps, sb, q, early);
    model_xfer(0, 1'b1, 4'd6, 8'hFF, 1'b1);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL wr_ro_slverr: got %b required 1", e); end
    checks++; if (sb !== 5'b0) begin errors++; $display("FAIL wr_ro_stb: got %b required 00000", sb); end
    checks++; if (q !== packed_bank(0)) begin errors++; $display("FAIL wr_ro_bank: got %h required %h", q, packed_bank(0)); end
    do_xfer(0, 1'b0, 4'd12, 8'h00, -1, n, rd, e, ps, sb, q, early);
    model_xfer(0, 1'b0, 4'd12, 8'h00, 1'b1);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL rd_unmapped_slverr: got %b required 1", e); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rd_unmapped_data: got %h required 00", rd); end
  endtask

  task automatic test_wait_states();
    int n; logic [7:0] rd; logic e; logic [2:0] ps; logic [4:0] sb; logic [39:0] q; bit early;
    do_xfer(2, 1'b1, 4'd0, 8'h11, -1, n, rd, e, ps, sb, q, early);
    model_xfer(2, 1'b1, 4'd0, 8'h11, 1'b1);
    checks++; if (n !== 3) begin errors++; $display("FAIL ws3_wr_latency: got %0d required 3", n); end
    do_xfer(2, 1'b0, 4'd0, 8'h00, -1, n, rd, e, ps, sb, q, early);
    checks++; if (n !== 3) begin errors++; $display("FAIL ws3_rd_latency: got %0d required 3", n); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL ws3_early_data: got %b required 0", early); end
    checks++; if (rd !== 8'h11) begin errors++; $display("FAIL ws3_rdata: got %h required 11", rd); end
  endtask

  task automatic test_back_to_back();
    int n; logic [7:0] rd; logic e; logic [2:0] ps; logic [4:0] sb; logic [39:0] q; bit early;
    do_xfer(1, 1'b1, 4'd1, 8'h77, 1, n, rd, e, ps, sb, q, early);
    model_xfer(1, 1'b1, 4'd1, 8'h77, 1'b0);
    checks++; if (sb !== 5'b0) begin errors++; $display("FAIL abort_stb: got %b required 00000", sb); end
    checks++; if (q[15:8] !== m_regw[1][1]) begin errors++; $display("FAIL abort_data: got %h required %h", q[15:8], m_regw[1][1]); end
    do_xfer(1, 1'b1, 4'd1, 8'h33, -1, n, rd, e, ps, sb, q, early);
    model_xfer(1, 1'b1, 4'd1, 8'h33, 1'b1);
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_latency: got %0d required 2", n); end
    checks++; if (sb !== 5'b00010) begin errors++; $display("FAIL b2b_stb: got %b required 00010", sb); end
    checks++; if (q[15:8] !== 8'h33) begin errors++; $display("FAIL b2b_data: got %h required 33", q[15:8]); end
  endtask

  task automatic test_protocol_error();
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'd3; pwdata = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      @(negedge PCLK);
      checks++; if (pready[0] !== 1'b0) begin errors++; $display("FAIL proto_ready cyc%0d: got %b required 0", c, pready[0]); end
    end
    psel[0] = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    checks++; if (regw_q[0] !== packed_bank(0)) begin errors++; $display("FAIL proto_bank: got %h required %h", regw_q[0], packed_bank(0)); end
  endtask

  task automatic test_random();
    int n; logic [7:0] rd; logic e; logic [2:0] ps; logic [4:0] sb; logic [39:0] q; bit early;
    int k; bit wr; logic [3:0] addr; logic [7:0] wd;
    logic [7:0] x_rd; logic x_e; logic [2:0] x_ps; logic [4:0] x_sb;
    for (int i = 0; i < 8; i++) status_val[i] = 8'($urandom);
    for (int t = 0; t < 60; t++) begin
      k = int'($urandom_range(2, 0)); wr = 1'($urandom); addr = 4'($urandom); wd = 8'($urandom);
      x_rd = exp_rdata(k, wr, addr);
      x_e  = exp_err(wr, addr);
      x_ps = (region(addr) == 1) ? 3'(addr - 4'd5) : m_pselr[k];
      x_sb = exp_stb(wr, addr);
      do_xfer(k, wr, addr, wd, -1, n, rd, e, ps, sb, q, early);
      model_xfer(k, wr, addr, wd, 1'b1);
      checks++; if (n !== ws_of(k)) begin errors++; $display("FAIL rnd%0d_latency dut%0d: got %0d required %0d", t, k, n, ws_of(k)); end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL rnd%0d_early dut%0d: got %b required 0", t, k, early); end
      checks++; if (rd !== x_rd) begin errors++; $display("FAIL rnd%0d_rdata dut%0d a=%0d: got %h required %h", t, k, addr, rd, x_rd); end
      checks++; if (e !== x_e) begin errors++; $display("FAIL rnd%0d_slverr dut%0d a=%0d: got %b required %b", t, k, addr, e, x_e); end
      checks++; if (ps !== x_ps) begin errors++; $display("FAIL rnd%0d_pselr dut%0d: got %0d required %0d", t, k, ps, x_ps); end
      checks++; if (sb !== x_sb) begin errors++; $display("FAIL rnd%0d_stb dut%0d: got %b required %b", t, k, sb, x_sb); end
      checks++; if (q !== packed_bank(k)) begin errors++; $display("FAIL rnd%0d_bank dut%0d: got %h required %h", t, k, q, packed_bank(k)); end
    end
  endtask

  task automatic test_reset_mid();
    int n; logic [7:0] rd; logic e; logic [2:0] ps; logic [4:0] sb; logic [39:0] q; bit early;
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd4; pwdata = 8'h99;
    @(posedge PCLK); #1 penable = 1'b1;
    @(negedge PCLK); #2 PRESETn = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({pready[1], pslverr[1], prdata[1], pselr[1], regw_q[1], stb_o[1]} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b err=%b rd=%h sel=%h q=%h stb=%b required all 0",
               pready[1], pslverr[1], prdata[1], pselr[1], regw_q[1], stb_o[1]);
    end
    @(posedge PCLK); #1 psel[1] = 1'b0; penable = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    @(negedge PCLK);
    checks++; if (regw_q[1][39:32] !== 8'h00) begin errors++; $display("FAIL midreset_reg4: got %h required 00", regw_q[1][39:32]); end
    do_xfer(1, 1'b0, 4'd4, 8'h00, -1, n, rd, e, ps, sb, q, early);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL midreset_read4: got %h required 00", rd); end
  endtask

  initial begin
    PRESETn = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    for (int k = 0; k < 3; k++) psel[k] = 1'b0;
    for (int i = 0; i < 8; i++) status_val[i] = 8'(8'h40 + i);
    model_reset();
    repeat (2) @(negedge PCLK);
    test_reset();
    PRESETn = 1'b1;
    @(negedge PCLK);
    test_write_ws0();
    test_read_ro();
    test_errors();
    test_wait_states();
    test_back_to_back();
    test_protocol_error();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_reg_ctrl.md
Name: apb_reg_ctrl

Overview:
- APB3 slave front-end for the task_3_abp register block; sits directly upstream of the read-status register block and owns the write/config register bank.
- Runs the SETUP/ACCESS handshake with optional wait states and decodes PADDR into a write-register index or a read-register select (pselr).
- Commits writes and returns PRDATA/PSLVERR. Read data comes from its own RW bank or from the downstream status block's data bus.

Parameters:
AWIDTH, 4, PADDR width (word address, no byte lanes)
DWIDTH, 8, data width
REGWN, 5, number of RW config registers, addresses 0..REGWN-1
REGRN, 3, number of RO status registers; also pselr width
REGR_ADDR_OFFSET, 5, first RO status address; RO range is OFFSET..OFFSET+REGRN-1
WAIT_STATES, 0, extra ACCESS cycles before PREADY (0..7)

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  1=write, 0=read
PADDR  in  AWIDTH  word address
PWDATA  in  DWIDTH  write data
PREADY  out  1  transfer complete
PSLVERR  out  1  error response, valid only with PREADY
PRDATA  out  DWIDTH  read data, valid only with PREADY and !PWRITE
pselr  out  REGRN  binary index of the selected status register, to the status block
regr_prdata  in  DWIDTH  data returned by the status block for pselr
regw_q  out  REGWN*DWIDTH  flattened RW register contents; reg i at [i*DWIDTH +: DWIDTH]
regw_wr_stb  out  REGWN  one-cycle pulse per register, high the cycle after its write commits

Behaviour:
- Reset (PRESETn low, async): state IDLE, wait counter 0, all regw_q 0, pselr 0, regw_wr_stb 0.
  - PREADY, PSLVERR and PRDATA are 0.
- States IDLE, ACCESS:
  - IDLE: PSEL=1 and PENABLE=0 is the SETUP phase. At that edge, latch PADDR and PWRITE, decode, load pselr with (PADDR-REGR_ADDR_OFFSET) if in RO range (else hold), clear counter, go to ACCESS.
  - IDLE with PENABLE=1 and no preceding setup: protocol error. Ignore it; no write, PREADY stays 0.
  - ACCESS: counter increments each cycle. PREADY is combinationally 1 when counter==WAIT_STATES and PSEL=PENABLE=1. With WAIT_STATES=0, the transfer completes in the first ACCESS cycle: 2-cycle transfer.
  - ACCESS with PREADY=1 returns to IDLE at the next edge. Back-to-back setup is then accepted from IDLE.
  - PSEL dropped during ACCESS: abort to IDLE, no write, no strobe.
- Address classes, decided from the latched address:
  - RW: addr < REGWN.
  - RO: OFFSET <= addr < OFFSET+REGRN.
  - Otherwise: unmapped.
- Write, RW address: regw[addr] <= PWDATA at the completing edge. regw_wr_stb[addr] is 1 for exactly the next cycle. PSLVERR=0.
- Write, RO or unmapped address: no state change, PSLVERR=1 with PREADY.
- Read:
  - RW address: PRDATA = regw[addr].
  - RO address: PRDATA = regr_prdata. pselr was stable since the SETUP edge, so the status block has at least one cycle.
  - Unmapped address: PRDATA = 0, PSLVERR=1.
- PRDATA = 0 whenever PREADY=0 or the transfer is a write.
- RW and RO ranges overlapping (bad parameters): RW wins.
- pselr holds its last value between transfers. It is not cleared on completion.
- Reset asserted mid-ACCESS aborts the transfer. A write in progress is not committed.

Decomposition:
- Shared package apb_pkg:
  - State encoding localparams (ST_IDLE, ST_ACCESS).
  - Address-class encoding (CLS_RW, CLS_RO, CLS_ERR).
  - A clog2 function for the wait-counter width.
- Sub-module apb_addr_decode (combinational): address in; class, RW index and RO index out. Reused by future APB slaves in task_3_abp.

Test Plan:
- Reset then write 0x5A to addr 2, WAIT_STATES=0 -> PREADY in 2nd cycle, PSLVERR=0; next cycle regw_wr_stb=5'b00100 and regw_q[23:16]=0x5A.
- Read addr 6 with regr_prdata driven 0xC3 when pselr==1 -> pselr=1 from SETUP edge; PRDATA=0xC3 with PREADY; PSLVERR=0.
- Write 0xFF to addr 6 (RO) and read addr 12 (unmapped) -> PSLVERR=1 both. For the write, regw_q is unchanged and no strobe. For the read, PRDATA=0.
- WAIT_STATES=3, read addr 0 after writing 0x11 -> PREADY low for 3 ACCESS cycles and high on the 4th; PRDATA=0x11 only then.
- Drop PSEL in ACCESS with WAIT_STATES=2 on a write of 0x77 to addr 1 -> FSM returns to IDLE, regw[1] unchanged, no strobe. A following back-to-back write of 0x33 to addr 1 completes normally.
- Assert PRESETn low mid-write to addr 4 -> all outputs 0 immediately (async), regw[4]=0 after release.
